cmdparse: RTL and testbench
===========================

Name: cmdparse

Overview:
Byte-stream request decoder that drives the command-request interface (req_stb/req_seq/req_we/req_adr/req_dat) into the wishbone command forwarder.
Sits between the host UART/USB receive byte stream and the command handler.
Frames incoming bytes, validates them, and emits one single-cycle request strobe per good frame.
Sequence numbers are passed through unmodified; sequence checking belongs downstream.

Parameters:
TIMEOUT_CYCLES, 1000, idle clocks allowed between bytes inside a frame before abandoning it; 0 disables the timeout.
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_data  in  8  received byte
rx_valid  in  1  rx_data valid this cycle; the block always accepts it (no backpressure)
req_stb_o  out  1  one-cycle pulse: a new request is valid
req_seq_o  out  6  request sequence number
req_we_o  out  1  1 = write, 0 = read
req_adr_o  out  16  request address
req_dat_o  out  8  write data (also forwarded on reads)
frame_err_o  out  1  one-cycle pulse on a rejected frame
err_count_o  out  8  count of rejected frames, saturating at 255

Behaviour:
- Frame format: SYNC, HDR, ADR_HI, ADR_LO, DAT [, CHK]. HDR = {we, rsvd(0), seq[5:0]}.
- Reset values: req_stb_o=0, frame_err_o=0, err_count_o=0, req_seq_o=0, req_we_o=0, req_adr_o=0, req_dat_o=0. State goes to HUNT and the timer clears.
- States: HUNT -> HDR -> ADR_HI -> ADR_LO -> DAT [-> CHK] -> HUNT. A state advances only on a cycle with rx_valid=1.
- HUNT: bytes not equal to SYNC_BYTE are discarded silently (no error). A SYNC byte moves the state to HDR.
- SYNC_BYTE seen after HUNT is ordinary payload and gets no special treatment.
- HDR: if bit 6 is set, the frame is rejected and the state returns to HUNT.
- Outputs req_* are updated together, and req_stb_o pulses high for exactly 1 cycle, on the cycle after the final byte is accepted.
  - The final byte is DAT, or CHK when the optional feature is compiled in.
- req_* outputs hold their values between strobes. Partial frames never modify them; the fields are staged in internal registers.
- Back-to-back frames: a SYNC arriving on the cycle req_stb_o is high is accepted normally.
- Timeout: the timer counts cycles with rx_valid=0 while state != HUNT, and clears on any accepted byte.
  - When the timer reaches TIMEOUT_CYCLES, the frame is rejected and the state returns to HUNT.
  - If rx_valid=1 on the expiry cycle, the byte wins and is processed normally.
- Reject: frame_err_o pulses for 1 cycle, err_count_o increments (saturating at 255, no wrap), no req_stb_o.
- rst asserted mid-frame: the partial frame is discarded, state goes to HUNT, and err_count_o clears.

Optional Feature:
CMDPARSE_CHECKSUM_EN.
- Defined: a CHK byte follows DAT, with CHK = HDR ^ ADR_HI ^ ADR_LO ^ DAT.
  - On a mismatch the frame is rejected and the state returns to HUNT.
  - The strobe is issued only after CHK matches.
- Undefined: no CHK byte; the frame ends at DAT and the CHK state and XOR register are absent.

Decomposition:
- Package cmdparse_pkg:
  - state encoding localparams (ST_HUNT, ST_HDR, ST_ADRH, ST_ADRL, ST_DAT, ST_CHK)
  - HDR bit positions (HDR_WE=7, HDR_RSVD=6, HDR_SEQ=5:0)
  - default SYNC_BYTE
- Sub-module cmdparse_timer: timeout counter with clear/enable inputs and an expire pulse output; counter width $clog2(TIMEOUT_CYCLES+1), tied off when TIMEOUT_CYCLES=0.

Test Plan:
- Write frame, checksum off: A5 83 12 34 56 -> one req_stb_o, 1 cycle after 56; seq=3, we=1, adr=0x1234, dat=0x56; no frame_err_o.
- Checksum on: A5 83 12 34 56 F3 -> strobe as above. Same frame with CHK=F2 -> no strobe, frame_err_o pulse, err_count_o=1.
- Noise and reserved bit: 00 FF A5 43 .. (bit 6 set) -> no strobe, err_count_o=1. The noise bytes 00 FF add no error.
- Timeout with TIMEOUT_CYCLES=10: A5 05 12, then 10 idle cycles -> frame_err_o. A following full frame A5 05 00 10 00 -> strobe with seq=5, we=0, adr=0x0010.
- Saturation and reset: 300 bad frames -> err_count_o stays 255. rst mid-frame (after A5 83) -> err_count_o=0, no strobe, next good frame strobes normally.
- Back-to-back: two frames with zero gap -> two strobes exactly 5 cycles apart (6 with CMDPARSE_CHECKSUM_EN); req_* hold the first frame's values until the second strobe.

Source files
------------

// File: rtl/cmdparse_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmdparse_pkg : shared state encoding, header layout, sync default    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cmdparse_pkg;

  localparam logic [2:0] ST_HUNT = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_ADRH = 3'd2;
  localparam logic [2:0] ST_ADRL = 3'd3;
  localparam logic [2:0] ST_DAT  = 3'd4;
  localparam logic [2:0] ST_CHK  = 3'd5;

  typedef enum logic [2:0] {
    S_HUNT = ST_HUNT,
    S_HDR  = ST_HDR,
    S_ADRH = ST_ADRH,
    S_ADRL = ST_ADRL,
    S_DAT  = ST_DAT,
    S_CHK  = ST_CHK
  } state_e;

  localparam int HDR_WE      = 7;
  localparam int HDR_RSVD    = 6;
  localparam int HDR_SEQ_MSB = 5;
  localparam int HDR_SEQ_LSB = 0;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/cmdparse_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmdparse_timer : inter-byte idle counter, pulses expire_o on the     |
// | idle cycle that brings the count to TIMEOUT_CYCLES (0 = disabled)    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cmdparse_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_on
      localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
      localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          expire;

      assign expire = en_i && !clr_i && (cnt_q == C_LAST);

      always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expire) begin
          cnt_d = '0;
        end else if (en_i) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expire_o = expire;
    end else begin : g_off
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst, clr_i, en_i};
      assign expire_o  = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/cmdparse.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmdparse : framed byte-stream request decoder (SYNC HDR ADRH ADRL    |
// | DAT [CHK]); CHK byte enabled by define CMDPARSE_CHECKSUM_EN          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cmdparse
  import cmdparse_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        req_stb_o,
  output logic [5:0]  req_seq_o,
  output logic        req_we_o,
  output logic [15:0] req_adr_o,
  output logic [7:0]  req_dat_o,
  output logic        frame_err_o,
  output logic [7:0]  err_count_o
);

  state_e      state_q, state_d;
  logic [7:0]  hdr_q, hdr_d;
  logic [7:0]  adrh_q, adrh_d;
  logic [7:0]  adrl_q, adrl_d;
`ifdef CMDPARSE_CHECKSUM_EN
  logic [7:0]  dat_q, dat_d;
  logic [7:0]  chk_q, chk_d;
`endif

  logic        req_stb_q, req_stb_d;
  logic [5:0]  req_seq_q, req_seq_d;
  logic        req_we_q, req_we_d;
  logic [15:0] req_adr_q, req_adr_d;
  logic [7:0]  req_dat_q, req_dat_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  err_count_q, err_count_d;

  logic        tmr_clr;
  logic        tmr_en;
  logic        tmr_expire;

  assign tmr_clr = (state_q == S_HUNT) || rx_valid;
  assign tmr_en  = !rx_valid;

  cmdparse_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .expire_o(tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    adrh_d      = adrh_q;
    adrl_d      = adrl_q;
`ifdef CMDPARSE_CHECKSUM_EN
    dat_d       = dat_q;
    chk_d       = chk_q;
`endif
    req_stb_d   = 1'b0;
    req_seq_d   = req_seq_q;
    req_we_d    = req_we_q;
    req_adr_d   = req_adr_q;
    req_dat_d   = req_dat_q;
    frame_err_d = 1'b0;

    if (rx_valid) begin
      unique case (state_q)
        S_HUNT: begin
          if (rx_data == SYNC_BYTE) state_d = S_HDR;
        end
        S_HDR: begin
          if (rx_data[HDR_RSVD]) begin
            frame_err_d = 1'b1;
            state_d     = S_HUNT;
          end else begin
            hdr_d   = rx_data;
            state_d = S_ADRH;
`ifdef CMDPARSE_CHECKSUM_EN
            chk_d   = rx_data;
`endif
          end
        end
        S_ADRH: begin
          adrh_d  = rx_data;
          state_d = S_ADRL;
`ifdef CMDPARSE_CHECKSUM_EN
          chk_d   = chk_q ^ rx_data;
`endif
        end
        S_ADRL: begin
          adrl_d  = rx_data;
          state_d = S_DAT;
`ifdef CMDPARSE_CHECKSUM_EN
          chk_d   = chk_q ^ rx_data;
`endif
        end
`ifdef CMDPARSE_CHECKSUM_EN
        S_DAT: begin
          dat_d   = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = S_CHK;
        end
        S_CHK: begin
          state_d = S_HUNT;
          if (rx_data == chk_q) begin
            req_stb_d = 1'b1;
            req_seq_d = hdr_q[HDR_SEQ_MSB:HDR_SEQ_LSB];
            req_we_d  = hdr_q[HDR_WE];
            req_adr_d = {adrh_q, adrl_q};
            req_dat_d = dat_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
`else
        S_DAT: begin
          state_d   = S_HUNT;
          req_stb_d = 1'b1;
          req_seq_d = hdr_q[HDR_SEQ_MSB:HDR_SEQ_LSB];
          req_we_d  = hdr_q[HDR_WE];
          req_adr_d = {adrh_q, adrl_q};
          req_dat_d = rx_data;
        end
`endif
        default: state_d = S_HUNT;
      endcase
    end else if (tmr_expire) begin
      frame_err_d = 1'b1;
      state_d     = S_HUNT;
    end

    // Saturate rather than wrap so a flood of bad frames stays visible.
    err_count_d = err_count_q;
    if (frame_err_d && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HUNT;
      hdr_q       <= '0;
      adrh_q      <= '0;
      adrl_q      <= '0;
`ifdef CMDPARSE_CHECKSUM_EN
      dat_q       <= '0;
      chk_q       <= '0;
`endif
      req_stb_q   <= 1'b0;
      req_seq_q   <= '0;
      req_we_q    <= 1'b0;
      req_adr_q   <= '0;
      req_dat_q   <= '0;
      frame_err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      adrh_q      <= adrh_d;
      adrl_q      <= adrl_d;
`ifdef CMDPARSE_CHECKSUM_EN
      dat_q       <= dat_d;
      chk_q       <= chk_d;
`endif
      req_stb_q   <= req_stb_d;
      req_seq_q   <= req_seq_d;
      req_we_q    <= req_we_d;
      req_adr_q   <= req_adr_d;
      req_dat_q   <= req_dat_d;
      frame_err_q <= frame_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign req_stb_o   = req_stb_q;
  assign req_seq_o   = req_seq_q;
  assign req_we_o    = req_we_q;
  assign req_adr_o   = req_adr_q;
  assign req_dat_o   = req_dat_q;
  assign frame_err_o = frame_err_q;
  assign err_count_o = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cmdparse.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cmdparse : directed self-checking bench for cmdparse              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_cmdparse;

  localparam int TMO = 10;
`ifdef CMDPARSE_CHECKSUM_EN
  localparam int FRAME_LEN = 6;
`else
  localparam int FRAME_LEN = 5;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        req_stb_o;
  logic [5:0]  req_seq_o;
  logic        req_we_o;
  logic [15:0] req_adr_o;
  logic [7:0]  req_dat_o;
  logic        frame_err_o;
  logic [7:0]  err_count_o;

  cmdparse #(
    .TIMEOUT_CYCLES(TMO),
    .SYNC_BYTE     (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .req_stb_o  (req_stb_o),
    .req_seq_o  (req_seq_o),
    .req_we_o   (req_we_o),
    .req_adr_o  (req_adr_o),
    .req_dat_o  (req_dat_o),
    .frame_err_o(frame_err_o),
    .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int stb_cnt = 0;
  int t_prev = 0;
  int t_last = 0;
  int exp_err = 0;
  int s0;
  logic [7:0] frm [6];
  int nb;

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (req_stb_o === 1'b1) begin
      stb_cnt++;
      t_prev = t_last;
      t_last = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic build(input logic we, input logic [5:0] seq, input logic [15:0] adr,
                       input logic [7:0] dat);
    frm[0] = 8'hA5;
    frm[1] = {we, 1'b0, seq};
    frm[2] = adr[15:8];
    frm[3] = adr[7:0];
    frm[4] = dat;
    frm[5] = frm[1] ^ frm[2] ^ frm[3] ^ frm[4];
    nb     = FRAME_LEN;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_range(input int from, input int to);
    for (int i = from; i <= to; i++) send_byte(frm[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Strobe must be high on the cycle right after the final byte, and only then.
  task automatic expect_req(input string tag, input logic we, input logic [5:0] seq,
                            input logic [15:0] adr, input logic [7:0] dat);
    @(negedge clk);
    check({tag, "_stb"}, {31'd0, req_stb_o}, 32'd1);
    check({tag, "_seq"}, {26'd0, req_seq_o}, {26'd0, seq});
    check({tag, "_we"},  {31'd0, req_we_o}, {31'd0, we});
    check({tag, "_adr"}, {16'd0, req_adr_o}, {16'd0, adr});
    check({tag, "_dat"}, {24'd0, req_dat_o}, {24'd0, dat});
    check({tag, "_noerr"}, {31'd0, frame_err_o}, 32'd0);
    @(negedge clk);
    check({tag, "_stb1cyc"}, {31'd0, req_stb_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_stb", {31'd0, req_stb_o}, 32'd0);
    check("rst_ferr", {31'd0, frame_err_o}, 32'd0);
    check("rst_cnt", {24'd0, err_count_o}, 32'd0);
    check("rst_req", {req_seq_o, req_we_o, req_adr_o, req_dat_o}, 32'd0);

    build(1'b1, 6'd3, 16'h1234, 8'h56);
`ifdef CMDPARSE_CHECKSUM_EN
    check("chk_byte", {24'd0, frm[5]}, 32'hF3);
`endif
    send_range(0, nb - 1);
    expect_req("wr", 1'b1, 6'd3, 16'h1234, 8'h56);
    check("wr_cnt", {24'd0, err_count_o}, 32'd0);

`ifdef CMDPARSE_CHECKSUM_EN
    build(1'b1, 6'd3, 16'h1234, 8'h56);
    frm[5] = 8'hF2;
    s0 = stb_cnt;
    send_range(0, nb - 1);
    @(negedge clk);
    check("badchk_ferr", {31'd0, frame_err_o}, 32'd1);
    exp_err++;
    idle(3);
    check("badchk_nostb", stb_cnt - s0, 32'd0);
    check("badchk_cnt", {24'd0, err_count_o}, exp_err);
`endif

    s0 = stb_cnt;
    send_byte(8'h00);
    send_byte(8'hFF);
    @(negedge clk);
    check("noise_cnt", {24'd0, err_count_o}, exp_err);
    send_byte(8'hA5);
    send_byte(8'h43);
    @(negedge clk);
    check("rsvd_ferr", {31'd0, frame_err_o}, 32'd1);
    exp_err++;
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h00);
    idle(3);
    check("rsvd_nostb", stb_cnt - s0, 32'd0);
    check("rsvd_cnt", {24'd0, err_count_o}, exp_err);

    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h12);
    idle(TMO - 1);
    @(negedge clk);
    check("tmo_early", {31'd0, frame_err_o}, 32'd0);
    idle(1);
    @(negedge clk);
    check("tmo_ferr", {31'd0, frame_err_o}, 32'd1);
    exp_err++;
    check("tmo_cnt", {24'd0, err_count_o}, exp_err);
    build(1'b0, 6'd5, 16'h0010, 8'h00);
    send_range(0, nb - 1);
    expect_req("aftmo", 1'b0, 6'd5, 16'h0010, 8'h00);

    repeat (300) begin
      send_byte(8'hA5);
      send_byte(8'h43);
    end
    idle(2);
    @(negedge clk);
    check("sat_cnt", {24'd0, err_count_o}, 32'd255);

    s0 = stb_cnt;
    send_byte(8'hA5);
    send_byte(8'h83);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_cnt", {24'd0, err_count_o}, 32'd0);
    idle(3);
    check("midrst_nostb", stb_cnt - s0, 32'd0);
    build(1'b1, 6'h3F, 16'hABCD, 8'hEF);
    send_range(0, nb - 1);
    expect_req("postrst", 1'b1, 6'h3F, 16'hABCD, 8'hEF);

    s0 = stb_cnt;
    build(1'b1, 6'h2A, 16'hBEEF, 8'h11);
    send_range(0, nb - 1);
    build(1'b0, 6'h01, 16'h0102, 8'h22);
    send_range(0, nb - 2);
    @(negedge clk);
    check("b2b_hold_adr", {16'd0, req_adr_o}, 32'h0000BEEF);
    check("b2b_hold_seq", {26'd0, req_seq_o}, 32'h2A);
    check("b2b_hold_dat", {24'd0, req_dat_o}, 32'h11);
    send_byte(frm[nb - 1]);
    expect_req("b2b2", 1'b0, 6'h01, 16'h0102, 8'h22);
    check("b2b_count", stb_cnt - s0, 32'd2);
    check("b2b_gap", t_last - t_prev, FRAME_LEN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
